// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART sender among NUM_REQ clients. A round-robin arbiter picks
//   a requesting client, latches its byte, and runs the sender req/ack
//   handshake. It then reserves FRAME_CYCLES clocks for the frame to go out
//   before it pulses done_o for that client.
//
//   Optional feature macro: UART_TX_ARB_TIMEOUT_EN
//     When defined, a REQ or REL handshake that stalls for ACK_TIMEOUT cycles
//     is aborted. err_o is then set and stays set until clr. When undefined,
//     err_o is tied 0 and no timeout counter exists.
//
// Ports
//   clk       system clock
//   clr       synchronous reset, active-high
//   req_i     level request per client (bit k = client k)
//   data_i    byte per client, client k at [8k+7:8k]
//   gnt_o     1-cycle pulse: client byte latched
//   done_o    1-cycle pulse: client frame time elapsed
//   busy_o    high whenever the FSM is not IDLE
//   snd_req   request to sender
//   snd_data  byte to sender, stable from grant until next grant
//   snd_ack   sender acknowledge
//   err_o     sticky ack-timeout flag
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int FRAME_CYCLES = 70000,
   parameter int ACK_TIMEOUT  = 4096
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [8*NUM_REQ-1:0]   data_i,
   output logic [NUM_REQ-1:0]     gnt_o,
   output logic [NUM_REQ-1:0]     done_o,
   output logic                   busy_o,
   output logic                   snd_req,
   output logic [7:0]             snd_data,
   input  logic                   snd_ack,
   output logic                   err_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(FRAME_CYCLES) + 1;
   localparam logic [IW:0]   NREQ      = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);
   localparam logic [TW-1:0] T_LOAD    = TW'(FRAME_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_WAIT, S_DONE} state_t;

   state_t               state_q;
   logic [IW-1:0]        last_q, idx_q;
   logic [TW-1:0]        timer_q;
   logic [NUM_REQ-1:0]   gnt_q, done_q;
   logic                 busy_q, snd_req_q;
   logic [7:0]           snd_data_q;

   // Round-robin pick: scan last+1, last+2, ... and wrap. The loop runs from
   // the farthest candidate to the nearest, so the nearest requester is the
   // last one assigned and wins. The previous winner (offset NUM_REQ) has the
   // lowest priority.
   logic                 win_vld_d;
   logic [IW-1:0]        win_idx_d;
   logic [7:0]           win_data_d;
   logic [IW:0]          cand;

   always_comb begin
      win_vld_d  = 1'b0;
      win_idx_d  = '0;
      win_data_d = 8'h00;
      cand       = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = {1'b0, last_q} + (IW+1)'(i);
         if (cand >= NREQ) cand = cand - NREQ;
         if (req_i[cand[IW-1:0]]) begin
            win_vld_d = 1'b1;
            win_idx_d = cand[IW-1:0];
         end
      end
      for (int k = 0; k < NUM_REQ; k++)
         if (win_idx_d == IW'(k)) win_data_d = data_i[8*k +: 8];
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int AW = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [AW-1:0] ATO_LAST = AW'(ACK_TIMEOUT - 1);
   logic [AW-1:0] ato_q;   // cycles spent in the current handshake phase
   logic          err_q;
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= S_IDLE;
         last_q     <= LAST_INIT;
         idx_q      <= '0;
         timer_q    <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         snd_req_q  <= 1'b0;
         snd_data_q <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
         ato_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (win_vld_d) begin
                  state_q          <= S_REQ;
                  busy_q           <= 1'b1;
                  gnt_q[win_idx_d] <= 1'b1;
                  snd_data_q       <= win_data_d;
                  idx_q            <= win_idx_d;
                  last_q           <= win_idx_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  ato_q            <= '0;
`endif
               end
            end
            S_REQ: begin
               if (snd_ack) begin
                  state_q   <= S_REL;
                  snd_req_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  ato_q     <= '0;
               end else if (ato_q == ATO_LAST) begin
                  // Sender never answered: drop the frame but still close it out.
                  state_q       <= S_DONE;
                  snd_req_q     <= 1'b0;
                  err_q         <= 1'b1;
                  done_q[idx_q] <= 1'b1;
`endif
               end else begin
                  snd_req_q <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  ato_q     <= ato_q + 1'b1;
`endif
               end
            end
            S_REL: begin
               if (!snd_ack) begin
                  state_q <= S_WAIT;
                  timer_q <= T_LOAD;
`ifdef UART_TX_ARB_TIMEOUT_EN
               end else if (ato_q == ATO_LAST) begin
                  // Ack stuck high: same abort as a missing ack.
                  state_q       <= S_DONE;
                  err_q         <= 1'b1;
                  done_q[idx_q] <= 1'b1;
               end else begin
                  ato_q <= ato_q + 1'b1;
`endif
               end
            end
            S_WAIT: begin
               if (timer_q == '0) begin
                  state_q       <= S_DONE;
                  done_q[idx_q] <= 1'b1;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               snd_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o    = gnt_q;
   assign done_o   = done_q;
   assign busy_o   = busy_q;
   assign snd_req  = snd_req_q;
   assign snd_data = snd_data_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
   assign err_o = err_q;
`else
   // ACK_TIMEOUT has no effect without the timeout feature; err_o stays 0.
   assign err_o = 1'b0 & (ACK_TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. A scoreboard queue holds the expected grants
// and the expected done pulses. The sender model raises ack 3 cycles after it
// sees req and drops ack 1 cycle after req falls.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int F  = 20;
   localparam int AT = 16;

   logic             clk = 1'b0;
   logic             clr;
   logic [N-1:0]     req_i;
   logic [8*N-1:0]   data_i;
   logic [N-1:0]     gnt_o, done_o;
   logic             busy_o, snd_req, snd_ack, err_o;
   logic [7:0]       snd_data;

   uart_tx_arbiter #(.NUM_REQ(N), .FRAME_CYCLES(F), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .clr(clr), .req_i(req_i), .data_i(data_i),
      .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
      .snd_req(snd_req), .snd_data(snd_data), .snd_ack(snd_ack), .err_o(err_o));

   always #5 clk = ~clk;

   typedef struct { int idx; logic [7:0] data; } exp_t;
   exp_t exp_q[$];
   int   pend_done[$];
   int   gcyc_q[$], dcyc_q[$];
   int   n_chk = 0, n_pass = 0;
   int   cyc = 0, gcnt = 0, dcnt = 0, ackfall_cnt = 0, ackfall_cyc = 0;
   int   sreq_rise = 0, sreq_fall_cyc = 0;
   logic ack_prev = 1'b0, sreq_prev = 1'b0;
   logic model_en = 1'b1;
   int   rc = 0;
   exp_t e;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   always @(posedge clk) cyc++;

   // Sender model
   always @(posedge clk) begin
      #1;
      if (clr || !model_en) begin snd_ack = 1'b0; rc = 0; end
      else if (snd_req && !snd_ack) begin rc++; if (rc == 4) snd_ack = 1'b1; end
      else if (!snd_req && snd_ack) begin snd_ack = 1'b0; rc = 0; end
   end

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (!clr) begin
         if (gnt_o != '0) begin
            gcnt++;
            gcyc_q.push_back(cyc);
            check("gnt_onehot", $countones(gnt_o), 1);
            if (exp_q.size() == 0) check("gnt_unexpected", gnt_o, 0);
            else begin
               e = exp_q.pop_front();
               check("gnt_client", gnt_o, 32'(1) << e.idx);
               check("snd_data", snd_data, e.data);
               pend_done.push_back(e.idx);
            end
         end
         if (done_o != '0) begin
            dcnt++;
            dcyc_q.push_back(cyc);
            if (pend_done.size() == 0) check("done_unexpected", done_o, 0);
            else check("done_client", done_o, 32'(1) << pend_done.pop_front());
         end
         if (ack_prev && !snd_ack) begin ackfall_cnt++; ackfall_cyc = cyc; end
         if (!sreq_prev && snd_req) sreq_rise++;
         if (sreq_prev && !snd_req) sreq_fall_cyc = cyc;
      end
      ack_prev  = snd_ack;
      sreq_prev = snd_req;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_gnt"},  gnt_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_sreq"}, snd_req, 0);
      check({tag, "_data"}, snd_data, 8'h00);
      check({tag, "_err"},  err_o, 0);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick(2);
      exp_q.delete(); pend_done.delete(); gcyc_q.delete(); dcyc_q.delete();
      gcnt = 0; dcnt = 0; sreq_rise = 0;
      clr = 1'b0;
   endtask

   task automatic push(input int idx);
      exp_t x;
      x.idx  = idx;
      x.data = data_i[8*idx +: 8];
      exp_q.push_back(x);
   endtask

   task automatic wait_gnt(input int n, input string tag);
      int k = 0;
      while (gcnt < n && k < 50 * (F + 10)) begin tick(1); k++; end
      check({tag, "_grants"}, gcnt, n);
   endtask

   task automatic wait_ackfall(input int n, input string tag);
      int k = 0;
      while (ackfall_cnt < n && k < 200) begin tick(1); k++; end
      check({tag, "_ackfall"}, ackfall_cnt, n);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((busy_o || pend_done.size() != 0) && k < 10 * (F + 10)) begin tick(1); k++; end
      tick(2);
      check({tag, "_idle_busy"}, busy_o, 0);
      check({tag, "_pend"}, pend_done.size(), 0);
      check({tag, "_exp_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int af;
      clr = 1'b1; req_i = '0; snd_ack = 1'b0;
      data_i = {8'h3C, 8'hA5, 8'h5A, 8'h11};
      tick(2);
      check_rst("reset");
      clr = 1'b0;
      // Test 1: single client 2, dropped request during busy is ignored
      do_reset();
      af = ackfall_cnt;
      push(2); req_i = 4'b0100;
      wait_gnt(1, "t1"); req_i = '0;
      wait_ackfall(af + 1, "t1");
      tick(3); req_i = 4'b1000; tick(2); req_i = '0;
      wait_idle("t1");
      check("t1_sreq_pulses", sreq_rise, 1);
      check("t1_ack_to_done", dcyc_q[0] - ackfall_cyc, F + 1);
      // Test 2: all clients held -> 0,1,2,3,0
      do_reset();
      push(0); push(1); push(2); push(3); push(0);
      req_i = 4'b1111;
      wait_gnt(5, "t2"); req_i = '0;
      wait_idle("t2");
      // Test 3a: clients 0,1 held -> 0,1,0,1
      do_reset();
      push(0); push(1); push(0); push(1);
      req_i = 4'b0011;
      wait_gnt(4, "t3a"); req_i = '0;
      wait_idle("t3a");
      // Test 3b: client 1 drops after first grant -> 0,0
      do_reset();
      push(0); push(0);
      req_i = 4'b0011;
      wait_gnt(1, "t3b"); req_i = 4'b0001;
      wait_gnt(2, "t3b"); req_i = '0;
      wait_idle("t3b");
      // Test 4: reset during WAIT aborts, pointer returns to client 0
      do_reset();
      af = ackfall_cnt;
      push(1); req_i = 4'b0010;
      wait_gnt(1, "t4"); req_i = '0;
      wait_ackfall(af + 1, "t4");
      tick(4);
      check("t4_busy_in_wait", busy_o, 1);
      clr = 1'b1; tick(1);
      check_rst("t4_abort");
      do_reset();
      tick(F + 10);
      check("t4_no_done", dcnt, 0);
      push(0); req_i = 4'b1111;
      wait_gnt(1, "t4b"); req_i = '0;
      wait_idle("t4b");
      // Test 6: single client held back-to-back
      do_reset();
      push(0); push(0); push(0);
      req_i = 4'b0001;
      wait_gnt(3, "t6"); req_i = '0;
      wait_idle("t6");
      check("t6_spacing1", gcyc_q[1] - gcyc_q[0], F + 8);
      check("t6_spacing2", gcyc_q[2] - gcyc_q[1], F + 8);
      check("t6_done_to_gnt", gcyc_q[1] - dcyc_q[0], 2);
`ifdef UART_TX_ARB_TIMEOUT_EN
      // Test 5: sender never acks
      do_reset();
      model_en = 1'b0;
      push(0); req_i = 4'b0001;
      wait_gnt(1, "t5"); req_i = '0;
      wait_idle("t5");
      check("t5_timeout_len", sreq_fall_cyc - gcyc_q[0], AT);
      check("t5_err_set", err_o, 1);
      tick(5);
      check("t5_err_sticky", err_o, 1);
      model_en = 1'b1;
      clr = 1'b1; tick(1);
      check("t5_err_clr", err_o, 0);
      clr = 1'b0;
`else
      check("err_tied", err_o, 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
